// File: rtl/gen_clk_multi_if.sv
// Bundle between the divided-clock generator and its consumer: run request in,
// divided clocks and status out. Optional tick strobes appear with GEN_CLK_TICK_EN.
interface gen_clk_multi_if #(
  parameter int unsigned N_OUT = 2
);
  logic             enb;
  logic [N_OUT-1:0] clk_div;
  logic             locked;
  logic             busy;
`ifdef GEN_CLK_TICK_EN
  logic [N_OUT-1:0] tick;

  modport master (output enb, input clk_div, input locked, input busy, input tick);
  modport slave  (input enb, output clk_div, output locked, output busy, output tick);
`else
  modport master (output enb, input clk_div, input locked, input busy);
  modport slave  (input enb, output clk_div, output locked, output busy);
`endif
endinterface

// File: rtl/gen_clk_multi.sv
// Phase-related power-of-two clock divider driven by one shared counter, with
// glitch-free start/drain control. GEN_CLK_TICK_EN adds per-output rise strobes.
module gen_clk_multi #(
  parameter int unsigned N_OUT          = 2,
  parameter int unsigned FIRST_DIV_LOG2 = 2
) (
  input  logic           clk_8f,
  input  logic           rst,
  gen_clk_multi_if.slave bus
);
  localparam int unsigned CNT_W = FIRST_DIV_LOG2 + N_OUT - 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q;
  logic             busy_q;
  logic             wrap;

  assign wrap = (cnt_q == CntMax);

  always_comb begin
    cnt_d = CNT_W'(cnt_q + 1'b1);
    if (state_q == StIdle) begin
      cnt_d = bus.enb ? CNT_W'(1'b1) : '0;
    end
  end

  always_ff @(posedge clk_8f or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      unique case (state_q)
        StIdle: begin
          if (bus.enb) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (!bus.enb) begin
            if (wrap) begin
              state_q  <= StIdle;
              locked_q <= 1'b0;
              busy_q   <= 1'b0;
            end else begin
              state_q <= StDrain;
            end
          end else if (wrap) begin
            locked_q <= 1'b1;
          end
        end
        StDrain: begin
          // A renewed request resumes without touching the counter phase.
          if (bus.enb) begin
            state_q <= StRun;
            if (wrap) locked_q <= 1'b1;
          end else if (wrap) begin
            state_q  <= StIdle;
            locked_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          locked_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clk_div = cnt_q[CNT_W-1:FIRST_DIV_LOG2-1];
  assign bus.locked  = locked_q;
  assign bus.busy    = busy_q;

`ifdef GEN_CLK_TICK_EN
  logic [N_OUT-1:0] tick_q;

  // Strobe lands in the cycle where the matching divided clock has just risen.
  always_ff @(posedge clk_8f or negedge rst) begin
    if (!rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= cnt_d[CNT_W-1:FIRST_DIV_LOG2-1] & ~cnt_q[CNT_W-1:FIRST_DIV_LOG2-1];
    end
  end

  assign bus.tick = tick_q;
`endif

endmodule

// File: tb/tb_gen_clk_multi.sv
// Directed bench for gen_clk_multi at default parameters (3-bit counter, /4 and /8).
module tb_gen_clk_multi;
  logic       clk_8f = 1'b0;
  logic       rst    = 1'b1;
  int         n_chk  = 0;
  int         n_pass = 0;
  logic [2:0] m      = 3'd0;

  always #2 clk_8f = ~clk_8f;

  gen_clk_multi_if #(.N_OUT(2)) bus ();

  gen_clk_multi #(
    .N_OUT          (2),
    .FIRST_DIV_LOG2 (2)
  ) dut (
    .clk_8f (clk_8f),
    .rst    (rst),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_div"}, 32'(bus.clk_div), 32'd0);
    chk({tag, "_lk"}, 32'(bus.locked), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  // One clk_8f edge with the generator counting; m tracks the expected counter.
  task automatic run_edge(input string tag, input logic exp_lk, input logic exp_busy);
    @(posedge clk_8f);
    #1;
    m = m + 3'd1;
    chk({tag, "_div"}, 32'(bus.clk_div), 32'({m[2], m[1]}));
    chk({tag, "_lk"}, 32'(bus.locked), 32'(exp_lk));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(exp_busy));
  endtask

  initial begin
    bus.enb = 1'b0;

    // Reset held for 10 ns with no run request.
    #1 rst = 1'b0;
    #1 chk_idle("t1_a");
    #5 chk_idle("t1_b");
    #4 chk_idle("t1_c");

    // Start: /4 rises after E1, /8 after E3, locked after E7.
    @(negedge clk_8f);
    rst     = 1'b1;
    bus.enb = 1'b1;
    for (int k = 0; k < 10; k++) run_edge("t2", k >= 7, 1'b1);
    for (int k = 0; k < 3; k++) run_edge("t2b", 1'b1, 1'b1);

    // Stop requested at cnt=5: drains through 6,7,0 then idles.
    bus.enb = 1'b0;
    run_edge("t3_6", 1'b1, 1'b1);
    run_edge("t3_7", 1'b1, 1'b1);
    run_edge("t3_0", 1'b0, 1'b0);
    @(posedge clk_8f);
    #1 chk_idle("t3_idle");

    // Restart, lock, then stop at cnt=3 and resume at cnt=5 from DRAIN.
    bus.enb = 1'b1;
    for (int k = 0; k < 8; k++) run_edge("t4_lock", k == 7, 1'b1);
    for (int k = 0; k < 3; k++) run_edge("t4_run", 1'b1, 1'b1);
    bus.enb = 1'b0;
    run_edge("t4_dr4", 1'b1, 1'b1);
    run_edge("t4_dr5", 1'b1, 1'b1);
    bus.enb = 1'b1;
    for (int k = 0; k < 4; k++) run_edge("t4_res", 1'b1, 1'b1);

    // Async reset between edges at cnt=6 while locked.
    for (int k = 0; k < 5; k++) run_edge("t5_pre", 1'b1, 1'b1);
    chk("t5_cnt6", 32'(bus.clk_div), 32'd3);
    #1 rst = 1'b0;
    #0.5 chk_idle("t5_async");
    @(negedge clk_8f);
    chk_idle("t5_held");
    m   = 3'd0;
    rst = 1'b1;
    for (int k = 0; k < 9; k++) run_edge("t5_rs", k >= 7, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
